// File: rtl/apu_pkg.sv
// Shared definitions for the APU output mixer: gain-ramp states, mix sizing
// and the default per-channel weights.
package apu_pkg;

    typedef enum logic [1:0] {
        MUTED = 2'd0,
        RISE  = 2'd1,
        UNITY = 2'd2,
        FALL  = 2'd3
    } gain_state_t;

    localparam int LEVEL_UNITY = 16;
    localparam int LEVEL_W     = 5;
    localparam int MIX_W       = 9;
    localparam int MIX_MAX     = 511;
    localparam int SUM_W       = 16;

    localparam int DEF_W_PULSE = 8;
    localparam int DEF_W_TRI   = 9;
    localparam int DEF_W_NOISE = 5;

endpackage

// File: rtl/pdm_modulator.sv
// First-order pulse-density modulator: the accumulator carry is the output bit,
// so a constant sample S yields exactly S ones in every 2**W cycles.
module pdm_modulator #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sample,
    output logic         pdm_out
);

    logic [W-1:0] acc_q;
    logic [W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, sample};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            pdm_out <= 1'b0;
        end else begin
            acc_q   <= acc_sum[W-1:0];
            pdm_out <= acc_sum[W];
        end
    end

endmodule

// File: rtl/apu_mixer.sv
// APU output mixer: weighted channel sum, soft-mute gain ramp and PDM audio
// output. Pipeline: inputs -> sum (1 cycle) -> gained mix_out (1 cycle) -> PDM.
module apu_mixer
    import apu_pkg::*;
#(
    parameter int W_PULSE = DEF_W_PULSE,
    parameter int W_TRI   = DEF_W_TRI,
    parameter int W_NOISE = DEF_W_NOISE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ramp_tick,
    input  logic       mute,
    input  logic [3:0] ch_en,
    input  logic [3:0] pulse1_in,
    input  logic [3:0] pulse2_in,
    input  logic [3:0] triangle_in,
    input  logic [3:0] noise_in,
    output logic [8:0] mix_out,
    output logic [4:0] level,
    output logic       muted,
    output logic       pdm_out
);

    localparam logic [LEVEL_W-1:0] LVL_TOP = LEVEL_W'(LEVEL_UNITY);

    // ---------------- stage 1: weighted, saturated channel sum
    logic [3:0]       p1, p2, tri_amp, noi;
    logic [SUM_W-1:0] raw_sum;
    logic [MIX_W-1:0] sum_d, sum_q;

    assign p1      = ch_en[0] ? pulse1_in   : 4'd0;
    assign p2      = ch_en[1] ? pulse2_in   : 4'd0;
    assign tri_amp = ch_en[2] ? triangle_in : 4'd0;
    assign noi     = ch_en[3] ? noise_in    : 4'd0;

    assign raw_sum = SUM_W'(W_PULSE) * (SUM_W'(p1) + SUM_W'(p2))
                   + SUM_W'(W_TRI)   * SUM_W'(tri_amp)
                   + SUM_W'(W_NOISE) * SUM_W'(noi);

    assign sum_d = (raw_sum > SUM_W'(MIX_MAX)) ? MIX_W'(MIX_MAX) : raw_sum[MIX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    // ---------------- gain ramp FSM
    gain_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUTED;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // A mute-driven direction change wins over a same-cycle tick, and the
    // level never steps past 0 or unity even if a direction flip lands there.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            MUTED: begin
                level_d = '0;
                if (!mute) state_d = RISE;
            end
            RISE: begin
                if (mute) begin
                    state_d = FALL;
                end else if (level_q >= LVL_TOP) begin
                    state_d = UNITY;
                    level_d = LVL_TOP;
                end else if (ramp_tick) begin
                    level_d = level_q + 5'd1;
                    if (level_q == LVL_TOP - 5'd1) state_d = UNITY;
                end
            end
            UNITY: begin
                level_d = LVL_TOP;
                if (mute) state_d = FALL;
            end
            FALL: begin
                if (!mute) begin
                    state_d = RISE;
                end else if (level_q == 5'd0) begin
                    state_d = MUTED;
                end else if (ramp_tick) begin
                    level_d = level_q - 5'd1;
                    if (level_q == 5'd1) state_d = MUTED;
                end
            end
            default: begin
                state_d = MUTED;
                level_d = '0;
            end
        endcase
    end

    assign level = level_q;
    assign muted = (state_q == MUTED);

    // ---------------- stage 2: apply gain (level/16, truncating)
    logic [13:0]      gain_prod;
    logic [MIX_W-1:0] mix_q;

    assign gain_prod = 14'(sum_q) * 14'(level_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mix_q <= '0;
        else        mix_q <= MIX_W'(gain_prod >> 4);
    end

    assign mix_out = mix_q;

    // ---------------- stage 3: audio pin
    pdm_modulator #(.W(MIX_W)) u_pdm (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (mix_q),
        .pdm_out (pdm_out)
    );

endmodule

// File: tb/tb_apu_mixer.sv
// Directed bench for apu_mixer: a default-weight instance and a W_PULSE=20
// instance share one stimulus stream; expectations are hand-computed.
module tb_apu_mixer;

    logic       clk = 1'b0;
    logic       rst_n, ramp_tick, mute;
    logic [3:0] ch_en, pulse1_in, pulse2_in, triangle_in, noise_in;
    logic [8:0] mix_a, mix_b;
    logic [4:0] level_a, level_b;
    logic       muted_a, muted_b, pdm_a, pdm_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apu_mixer dut_a (
        .clk(clk), .rst_n(rst_n), .ramp_tick(ramp_tick), .mute(mute), .ch_en(ch_en),
        .pulse1_in(pulse1_in), .pulse2_in(pulse2_in), .triangle_in(triangle_in),
        .noise_in(noise_in), .mix_out(mix_a), .level(level_a), .muted(muted_a),
        .pdm_out(pdm_a)
    );

    apu_mixer #(.W_PULSE(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .ramp_tick(ramp_tick), .mute(mute), .ch_en(ch_en),
        .pulse1_in(pulse1_in), .pulse2_in(pulse2_in), .triangle_in(triangle_in),
        .noise_in(noise_in), .mix_out(mix_b), .level(level_b), .muted(muted_b),
        .pdm_out(pdm_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        ramp_tick = 1'b1;
        step(1);
        ramp_tick = 1'b0;
        step(7);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] en, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] t, input logic [3:0] nz);
        ch_en = en; pulse1_in = a; pulse2_in = b; triangle_in = t; noise_in = nz;
    endtask

    initial begin
        int ones_a, ones_b;
        rst_n = 1'b0; ramp_tick = 1'b0; mute = 1'b0;
        set_in(4'hF, 4'd15, 4'd15, 4'd15, 4'd15);
        step(2);
        chk("rst_level", 16'(level_a), 16'd0);
        chk("rst_muted", 16'(muted_a), 16'd1);
        chk("rst_mix",   16'(mix_a),   16'd0);
        chk("rst_pdm",   16'(pdm_a),   16'd0);

        // soft start: MUTED -> RISE, then 16 ticks to unity
        rst_n = 1'b1;
        step(1);
        chk("rise_muted", 16'(muted_a), 16'd0);
        chk("rise_level0", 16'(level_a), 16'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("ramp_up_%0d", i), 16'(level_a), 16'(i));
        end
        step(2);
        chk("unity_mix_450", 16'(mix_a), 16'd450);
        chk("unity_mix_sat", 16'(mix_b), 16'd511);
        tick();
        chk("unity_hold", 16'(level_a), 16'd16);

        // single pulse channel, then masked off
        set_in(4'hF, 4'd15, 4'd0, 4'd0, 4'd0);
        step(2);
        chk("p1_mix_a", 16'(mix_a), 16'd120);
        chk("p1_mix_b", 16'(mix_b), 16'd300);
        ch_en = 4'b1110;
        step(2);
        chk("p1_masked", 16'(mix_a), 16'd0);

        // PDM density over a 512-cycle window
        ch_en = 4'hF;
        step(2);
        ones_a = 0; ones_b = 0;
        for (int i = 0; i < 512; i++) begin
            step(1);
            ones_a += int'(pdm_a);
            ones_b += int'(pdm_b);
        end
        chk("pdm_ones_120", 16'(ones_a), 16'd120);
        chk("pdm_ones_300", 16'(ones_b), 16'd300);
        set_in(4'h0, 4'd15, 4'd0, 4'd0, 4'd0);
        step(3);
        ones_a = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            ones_a += int'(pdm_a);
        end
        chk("pdm_idle_zero", 16'(ones_a), 16'd0);

        // fall to 9, then mute release coinciding with a tick
        set_in(4'hF, 4'd15, 4'd15, 4'd15, 4'd15);
        mute = 1'b1;
        step(1);
        chk("fall_hold16", 16'(level_a), 16'd16);
        for (int i = 0; i < 7; i++) tick();
        chk("fall_level9", 16'(level_a), 16'd9);
        mute = 1'b0; ramp_tick = 1'b1;
        step(1);
        ramp_tick = 1'b0;
        chk("flip_level9", 16'(level_a), 16'd9);
        chk("flip_muted", 16'(muted_a), 16'd0);
        step(7);
        tick();
        chk("flip_next_10", 16'(level_a), 16'd10);

        // gain arithmetic at level 8 and level 1
        mute = 1'b1;
        step(1);
        tick(); tick();
        chk("fall_level8", 16'(level_a), 16'd8);
        chk("gain8_mix_a", 16'(mix_a), 16'd225);
        chk("gain8_mix_b", 16'(mix_b), 16'd255);
        for (int i = 0; i < 7; i++) tick();
        chk("fall_level1", 16'(level_a), 16'd1);
        set_in(4'hF, 4'd0, 4'd0, 4'd0, 4'd3);
        step(2);
        chk("gain1_trunc", 16'(mix_a), 16'd0);
        tick();
        chk("fall_level0", 16'(level_a), 16'd0);
        chk("fall_muted", 16'(muted_a), 16'd1);

        // async reset in the middle of a rise
        set_in(4'hF, 4'd15, 4'd15, 4'd15, 4'd15);
        mute = 1'b0;
        step(1);
        tick(); tick(); tick();
        chk("mid_rise_level3", 16'(level_a), 16'd3);
        chk("mid_rise_mix_a", 16'(mix_a), 16'd84);
        chk("mid_rise_mix_b", 16'(mix_b), 16'd95);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 16'(level_a), 16'd0);
        chk("arst_muted", 16'(muted_a), 16'd1);
        chk("arst_mix_a", 16'(mix_a),   16'd0);
        chk("arst_mix_b", 16'(mix_b),   16'd0);
        chk("arst_pdm",   16'({pdm_a, pdm_b}), 16'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("recover_rise", 16'(muted_a), 16'd0);
        tick();
        chk("recover_level1", 16'(level_b), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apu_mixer.md
Name: apu_mixer

Overview:
Downstream stage of the sound generator: combines the 4-bit channel amplitudes (pulse 1, pulse 2, triangle, noise) into one weighted 9-bit mix and applies a pop-free soft-mute gain ramp. It then drives the audio pin through a first-order pulse-density modulator. It replaces the direct wiring of pulse bit 0 to the PWM pin and runs on the 1.79 MHz APU clock.

Parameters:
W_PULSE, 8, integer weight per pulse-channel step
W_TRI, 9, integer weight per triangle step
W_NOISE, 5, integer weight per noise step

Ports:
clk  input  1  APU system clock
rst_n  input  1  asynchronous active-low reset
ramp_tick  input  1  one-cycle gain-ramp strobe (240 Hz frame enable)
mute  input  1  level request: 1 = ramp to silence, 0 = ramp to unity
ch_en  input  4  channel enable mask {noise, tri, pulse2, pulse1}; 0 forces that channel to 0
pulse1_in  input  4  pulse 1 amplitude
pulse2_in  input  4  pulse 2 amplitude
triangle_in  input  4  triangle amplitude
noise_in  input  4  noise amplitude
mix_out  output  9  gained mix sample (test and debug)
level  output  5  current gain 0..16 (16 = unity)
muted  output  1  high while state is MUTED
pdm_out  output  1  pulse-density audio output

Behaviour:
- Clock and reset: single clock `clk`. `rst_n` is asynchronous and active-low. All registers clear on reset; no other reset source.
- Reset values: mix_out=0, level=0, muted=1, pdm_out=0, PDM accumulator=0, state=MUTED, stage-1 sum=0.
- Stage 1 (registered, 1 cycle):
  - Each input is ANDed with its ch_en bit.
  - sum = W_PULSE*(p1+p2) + W_TRI*tri + W_NOISE*noise, computed at ≥11 bits.
  - Saturate to 511 if the result exceeds 511. With the defaults the maximum is 450, so no saturation occurs.
- Stage 2 (registered, 1 cycle): mix_out = (sum*level)>>4, truncating. level=16 gives mix_out=sum exactly.
- Latency: input change to mix_out is 2 cycles. Gain uses the level value registered in the same cycle as stage-2 capture.
- Gain FSM states: MUTED, RISE, UNITY, FALL.
  - MUTED: level=0. mute=0 → RISE next cycle.
  - RISE: mute=1 → FALL, level held. Else on ramp_tick, level+1; when level reaches 16 → UNITY.
  - UNITY: level=16. mute=1 → FALL.
  - FALL: mute=0 → RISE, level held. Else on ramp_tick, level-1; when level reaches 0 → MUTED.
  - A state change caused by mute takes priority over ramp_tick in the same cycle: level is not stepped that cycle.
  - level is never outside 0..16. A full ramp takes 16 ticks (≈66.7 ms at 240 Hz).
  - After reset with mute=0, the block soft-starts: MUTED → RISE → UNITY.
- PDM (stage 3):
  - {carry, acc[8:0]} = acc + mix_out.
  - acc takes the low 9 bits; pdm_out is registered from carry.
  - Over 512 cycles, the count of ones equals mix_out exactly when mix_out is held constant.
  - mix_out=0 → pdm_out held 0. No idle-state glitch.
- Asynchronous reset mid-ramp or mid-frame immediately returns everything to the reset values. Recovery follows the same soft-start.
- Inputs are assumed synchronous to clk; no synchronizers inside.

Decomposition:
- Shared package `apu_pkg`:
  - gain state enum (MUTED, RISE, UNITY, FALL)
  - constants LEVEL_UNITY=16, MIX_W=9, MIX_MAX=511
  - default channel weights
- One sub-module `pdm_modulator` (clk, rst_n, 9-bit sample in, 1-bit out). It is reusable for any later DAC output.

Test Plan:
- Reset with mute=0, all channels 15, ch_en=4'hF, ramp_tick every 8 cycles:
  - muted=1, level=0 after reset
  - level steps 1..16 on successive ticks; UNITY after the 16th tick
  - mix_out=450 two cycles after level=16
- Unity gain, p1=15 and all other inputs 0 → mix_out=120. Set ch_en=4'b1110 → mix_out=0 two cycles later.
- mix_out held at 120 → exactly 120 ones on pdm_out in any 512-cycle window. mix_out=0 → pdm_out never 1.
- Gain arithmetic: level=8, sum=450 → mix_out=225. level=1, sum=15 → mix_out=0 (truncation).
- Ramp edge cases:
  - mute toggles 1→0 during FALL at level=9, same cycle as ramp_tick → state RISE, level stays 9.
  - Next tick → level=10.
- Weight override W_PULSE=20, all inputs 15 → sum saturates, mix_out=511 at unity. Reset asserted mid-RISE → all outputs return to reset values asynchronously.
